// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, R/W encoding and
// on-board device addresses used by both initiator and target.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_PTR,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } i2c_tgt_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic [6:0] I2C_ADDR_TOUCH = 7'h38;
    localparam logic [6:0] I2C_ADDR_RTC   = 7'h68;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP detection.
// Events appear SYNC_STAGES+1 clocks after the pin change.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_q;
    logic [SYNC_STAGES-1:0] sda_q;
    logic                   scl_p;
    logic                   sda_p;
    logic                   scl_s;

    // Idle bus is high; resetting to 1 avoids spurious events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl_in};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda_in};
            scl_p <= scl_s;
            sda_p <= sda_s;
        end
    end

    assign scl_s     = scl_q[SYNC_STAGES-1];
    assign sda_s     = sda_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target exposing a byte-addressed register file with a host
// preload port and strobes for bytes written by the initiator.
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h68,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        AW          = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          bus_wr_valid,
    output logic [AW-1:0] bus_wr_addr,
    output logic [7:0]    bus_wr_data,
    output logic          busy
);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_tgt_state_t state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          oe_n, busy_n;
    logic          rw, rw_n;
    logic          ph, ph_n;
    logic          bw_en;
    logic [AW-1:0] bw_addr;
    logic [7:0]    bw_data;
    logic [7:0]    regs [NUM_REGS];

    assign host_rdata = regs[host_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            ptr          <= '0;
            sda_oe       <= 1'b0;
            busy         <= 1'b0;
            rw           <= I2C_RW_WRITE;
            ph           <= 1'b0;
            bus_wr_valid <= 1'b0;
            bus_wr_addr  <= '0;
            bus_wr_data  <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            shreg        <= shreg_n;
            ptr          <= ptr_n;
            sda_oe       <= oe_n;
            busy         <= busy_n;
            rw           <= rw_n;
            ph           <= ph_n;
            bus_wr_valid <= bw_en;
            if (bw_en) begin
                bus_wr_addr <= bw_addr;
                bus_wr_data <= bw_data;
            end
        end
    end

    // Host port has priority when both hit the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (host_we && host_addr == AW'(i))
                    regs[i] <= host_wdata;
                else if (bw_en && bw_addr == AW'(i))
                    regs[i] <= bw_data;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        ptr_n   = ptr;
        oe_n    = sda_oe;
        busy_n  = busy;
        rw_n    = rw;
        ph_n    = ph;
        bw_en   = 1'b0;
        bw_addr = ptr;
        bw_data = {shreg[6:0], sda_s};

        if (stop_det) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            cnt_n   = '0;
            ph_n    = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            oe_n    = 1'b0;
            cnt_n   = '0;
            ph_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR, WR_PTR, WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n = {shreg[6:0], sda_s};
                        cnt_n   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n = '0;
                            if (state == ADDR) begin
                                if (shreg_n[7:1] == DEV_ADDR) begin
                                    state_n = ADDR_ACK;
                                    busy_n  = 1'b1;
                                    rw_n    = sda_s ? I2C_RW_READ : I2C_RW_WRITE;
                                end else begin
                                    state_n = IDLE;
                                    busy_n  = 1'b0;
                                end
                            end else if (state == WR_PTR) begin
                                ptr_n   = shreg_n[AW-1:0];
                                state_n = WR_ACK;
                            end else begin
                                bw_en   = 1'b1;
                                ptr_n   = ptr + 1'b1;
                                state_n = WR_ACK;
                            end
                        end
                    end
                end
                // ph marks that the 9th rising edge has been seen.
                ADDR_ACK, WR_ACK: begin
                    if (scl_rise) begin
                        ph_n = 1'b1;
                    end else if (scl_fall) begin
                        if (!ph) begin
                            oe_n = 1'b1;
                        end else begin
                            ph_n = 1'b0;
                            oe_n = 1'b0;
                            if (state == WR_ACK) begin
                                state_n = WR_DATA;
                            end else if (rw == I2C_RW_READ) begin
                                state_n = RD_DATA;
                                shreg_n = regs[ptr];
                                oe_n    = ~regs[ptr][7];
                            end else begin
                                state_n = WR_PTR;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            ph_n    = 1'b0;
                            state_n = RD_ACK;
                        end else begin
                            oe_n    = ~shreg[6];
                            shreg_n = {shreg[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            ptr_n = ptr + 1'b1;
                            ph_n  = 1'b1;
                        end
                    end else if (scl_fall && ph) begin
                        ph_n    = 1'b0;
                        state_n = RD_DATA;
                        shreg_n = regs[ptr];
                        oe_n    = ~regs[ptr][7];
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed and randomized bus transactions against a register-map
// model of the I2C target.
module tb_i2c_target_responder;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic [7:0] host_rdata;
    logic       bus_wr_valid;
    logic [3:0] bus_wr_addr;
    logic [7:0] bus_wr_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mregs [16];
    int          mptr;
    logic [7:0]  dbuf [8];
    logic [11:0] wq [$];
    int          oe_cnt = 0;
    int          busy_cnt = 0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_responder dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .bus_wr_valid(bus_wr_valid),
        .bus_wr_addr (bus_wr_addr),
        .bus_wr_data (bus_wr_data),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (bus_wr_valid) wq.push_back({bus_wr_addr, bus_wr_data});
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (Q) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; q();
        scl = 1'b1;   q();
        sda_m = 1'b0; q();
        scl = 1'b0;   q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; q();
        scl = 1'b1;   q();
        sda_m = 1'b1; q();
        q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; q();
        scl = 1'b1; q(); q();
        scl = 1'b0; q();
    endtask

    task automatic wb(input logic [7:0] b, input logic exp_ack, input string tag);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; q();
        scl = 1'b1;   q();
        a = ~sda_line; q();
        scl = 1'b0;   q();
        chk(tag, a, exp_ack);
    endtask

    task automatic rb(input logic nack, output logic [7:0] b);
        b = '0;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q();
            scl = 1'b1; q();
            b = {b[6:0], sda_line}; q();
            scl = 1'b0; q();
        end
        send_bit(nack);
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        mregs[a] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            host_addr = 4'(i);
            #1;
            chk(tag, host_rdata, mregs[i]);
        end
    endtask

    // Pointer write followed by n data bytes from dbuf.
    task automatic do_write(input logic [7:0] p, input int n);
        int a;
        bus_start();
        wb(8'hD0, 1'b1, "wr_addr_ack");
        chk("busy_mid", busy, 1'b1);
        wb(p, 1'b1, "wr_ptr_ack");
        for (int i = 0; i < n; i++) wb(dbuf[i], 1'b1, "wr_data_ack");
        bus_stop();
        chk("busy_after_stop", busy, 1'b0);
        chk("oe_after_stop", sda_oe, 1'b0);
        chk("pulse_count", wq.size(), n);
        for (int i = 0; i < n; i++) begin
            a = (int'(p) + i) % 16;
            if (wq.size() > 0) chk("pulse", wq.pop_front(), {4'(a), dbuf[i]});
            mregs[a] = dbuf[i];
        end
        wq.delete();
        mptr = (int'(p) + n) % 16;
    endtask

    // Read n bytes; p < 0 reads from the current pointer.
    task automatic do_read(input int p, input int n);
        logic [7:0] b;
        int base;
        base = (p < 0) ? mptr : p % 16;
        bus_start();
        if (p >= 0) begin
            wb(8'hD0, 1'b1, "rd_waddr_ack");
            wb(8'(p), 1'b1, "rd_ptr_ack");
            bus_start();
        end
        wb(8'hD1, 1'b1, "rd_addr_ack");
        for (int i = 0; i < n; i++) begin
            rb(i == n - 1, b);
            chk("rd_byte", b, mregs[(base + i) % 16]);
        end
        chk("oe_after_nack", sda_oe, 1'b0);
        chk("busy_after_nack", busy, 1'b0);
        bus_stop();
        mptr = (base + n - 1) % 16;
    endtask

    initial begin
        int oe0, busy0, n;
        logic [7:0] p;

        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mptr = 0;

        repeat (5) @(posedge clk);
        #1;
        chk("rst_oe", sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", bus_wr_valid, 1'b0);
        chk("rst_reg0", host_rdata, 8'h00);
        reset = 1'b1;
        repeat (5) @(posedge clk);

        dbuf[0] = 8'h12; dbuf[1] = 8'h34;
        do_write(8'h03, 2);
        check_regs("reg_after_write");

        host_wr(4'd5, 8'hA5);
        host_wr(4'd6, 8'h3C);
        do_read(5, 2);

        oe0 = oe_cnt; busy0 = busy_cnt;
        bus_start();
        wb(8'hA0, 1'b0, "mismatch_addr_nack");
        wb(8'h03, 1'b0, "mismatch_b1_nack");
        wb(8'h55, 1'b0, "mismatch_b2_nack");
        bus_stop();
        chk("mismatch_oe_quiet", oe_cnt - oe0, 0);
        chk("mismatch_busy_quiet", busy_cnt - busy0, 0);
        chk("mismatch_no_pulse", wq.size(), 0);
        check_regs("mismatch_regs");

        dbuf[0] = 8'h11; dbuf[1] = 8'h22;
        do_write(8'h0F, 2);
        chk("wrap_reg15", mregs[15], 8'h11);
        check_regs("wrap_regs");

        bus_start();
        wb(8'hD0, 1'b1, "abort_addr_ack");
        wb(8'h01, 1'b1, "abort_ptr_ack");
        mptr = 1;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        repeat (4) @(posedge clk);
        chk("abort_no_pulse", wq.size(), 0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_oe", sda_oe, 1'b0);
        check_regs("abort_regs");
        do_read(-1, 1);

        repeat (4) begin
            p = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
            do_write(p, n);
            if ($urandom_range(0, 1) == 1)
                host_wr(4'($urandom_range(0, 15)), 8'($urandom));
            do_read(int'(p), n);
            do_read(-1, 1);
        end
        check_regs("rand_regs");

        host_wr(4'd2, 8'h12);
        do_write(8'h02, 0);
        bus_start();
        wb(8'hD1, 1'b1, "rst_rd_addr_ack");
        chk("rst_rd_oe_driven", sda_oe, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_rd_oe_released", sda_oe, 1'b0);
        repeat (3) @(posedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mptr = 0;
        bus_stop();
        check_regs("rst_rd_regs");
        host_wr(4'd0, 8'h5A);
        do_read(-1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
Synthesizable I2C target (slave) that answers an on-board I2C initiator. It exposes a small byte-addressed register file that looks like an RTC or touch-controller register map. Fabric logic preloads the register contents through a host port, and bus writes from the initiator are reported back as strobes. It is used as a loop-back and bring-up target for the I2C initiator, and as a peripheral emulator.

Parameters:
DEV_ADDR, 7'h68, 7-bit target address matched on the bus
NUM_REGS, 16, register count; must be a power of two, at most 256
SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (at least 2)

Ports:
clk  input  1  system clock; must be at least 8x the SCL frequency
reset  input  1  asynchronous, active-low
scl_in  input  1  SCL pad input (target never stretches the clock)
sda_in  input  1  SDA pad input
sda_oe  output  1  1 = pull SDA low (pad is driven low when 1, otherwise Z)
host_we  input  1  host write strobe
host_addr  input  $clog2(NUM_REGS)  host register index
host_wdata  input  8  host write data
host_rdata  output  8  reg[host_addr], combinational read
bus_wr_valid  output  1  one-clk pulse per data byte written by the initiator
bus_wr_addr  output  $clog2(NUM_REGS)  register written
bus_wr_data  output  8  byte written
busy  output  1  1 from an address-matched START until STOP, NACK-terminated read, or mismatch

Behaviour:
- Reset values: sda_oe=0, busy=0, bus_wr_valid=0, all regs=0, ptr=0, state=IDLE. Reset is asynchronous and releases SDA immediately, including mid-transaction.
- Inputs pass through SYNC_STAGES flops plus one edge-detect flop. Bus events are therefore seen SYNC_STAGES+1 clks after the pin change.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in every state.
  - START (including a repeated START) → state ADDR, bit counter = 0.
  - STOP → IDLE, sda_oe=0, busy=0.
- Data bits are sampled on SCL rising edges. sda_oe changes only on SCL falling edges, except for STOP and reset.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits plus R/W).
    - Address match → ADDR_ACK.
    - Mismatch → IDLE; stay silent until the next START.
  - ADDR_ACK: sda_oe=1 from the falling edge after bit 8 until the falling edge after the 9th clock.
    - R/W=0 → WR_PTR.
    - R/W=1 → RD_DATA; load the shift register with reg[ptr].
  - WR_PTR: receive 8 bits; ptr = byte[$clog2(NUM_REGS)-1:0] (upper bits ignored); then ACK → WR_DATA.
  - WR_DATA: receive byte → reg[ptr] written, bus_wr_valid pulses for 1 clk with the pre-increment ptr; ptr increments; ACK; stay in WR_DATA.
  - RD_DATA: drive bit 7 first. sda_oe = ~bit on each falling edge; releasing the line outputs a 1. After 8 bits, release SDA → RD_ACK.
  - RD_ACK: sample SDA on the 9th rising edge.
    - ACK (0): ptr increments, reload from reg[ptr], → RD_DATA.
    - NACK (1): release the bus → IDLE (busy=0), then wait for STOP or START.
- The pointer wraps modulo NUM_REGS on both reads and writes.
- The pointer persists across transactions. A read without a prior pointer write starts at the last ptr.
- Simultaneous host_we and bus write to the same register in the same clk: the host write wins, and bus_wr_valid still pulses with the bus data.
- A host write to the register currently in the read shift register does not affect the byte in flight. It takes effect on the next load.
- START or STOP mid-byte aborts the byte. No register write and no bus_wr_valid pulse occur.

Decomposition:
- Shared package i2c_pkg:
  - i2c_tgt_state_t enum (IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK)
  - I2C_RW_WRITE/I2C_RW_READ constants
  - touch and RTC device-address constants, shared with the initiator
- One sub-module: i2c_line_sync. It handles synchronization, SCL rise/fall detection, and start/stop detection, and outputs scl_rise, scl_fall, sda_s, start_det, stop_det.

Test Plan:
- Pointer write plus data: START, 0xD0, 0x03, 0x12, 0x34, STOP → every byte ACKed; reg[3]=0x12, reg[4]=0x34; two bus_wr_valid pulses with addr 3 then 4.
- Combined read: host preloads reg[5]=0xA5, reg[6]=0x3C; START 0xD0 0x05, repeated START 0xD1, read with ACK then NACK, STOP → initiator receives 0xA5, 0x3C; SDA released after the NACK.
- Address mismatch: START 0xA0 then 2 bytes → sda_oe stays 0 throughout, busy stays 0, regs unchanged.
- Pointer wrap: write ptr 0x0F then 0x11, 0x22 → reg[15]=0x11, reg[0]=0x22.
- Aborted byte: STOP after 4 data bits → no write, no bus_wr_valid pulse, state IDLE, sda_oe=0.
- Reset mid-read: assert reset while sda_oe=1 during RD_DATA → sda_oe=0 within the same clk; regs and ptr are 0 after release.
